// File: rtl/partition_sweep_ctrl_if.sv
// rtl/partition_sweep_ctrl_if.sv - partition sweep request, pattern/response and result bundle
interface partition_sweep_ctrl_if #(
    parameter int N_IN  = 5,
    parameter int N_OUT = 7,
    parameter int HD_W  = $clog2(N_OUT + 1)
);
    logic                   start;
    logic [N_OUT-1:0]       po_exact;
    logic [N_OUT-1:0]       po_approx;
    logic [N_IN-1:0]        pi;
    logic                   busy;
    logic                   done;
    logic [N_IN:0]          err_count;
    logic [N_IN+HD_W-1:0]   hd_sum;
    logic [HD_W-1:0]        max_hd;
    logic                   first_err_vld;
    logic [N_IN-1:0]        first_err_pat;

    modport master (
        output start, po_exact, po_approx,
        input  pi, busy, done, err_count, hd_sum, max_hd, first_err_vld, first_err_pat
    );

    modport slave (
        input  start, po_exact, po_approx,
        output pi, busy, done, err_count, hd_sum, max_hd, first_err_vld, first_err_pat
    );
endinterface

// File: rtl/partition_sweep_ctrl.sv
// rtl/partition_sweep_ctrl.sv - exhaustive input sweep and error-metric accumulation for one partition
module partition_sweep_ctrl #(
    parameter int N_IN   = 5,
    parameter int N_OUT  = 7,
    parameter int SETTLE = 1,
    parameter int HD_W   = $clog2(N_OUT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    partition_sweep_ctrl_if.slave sweep
);
    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t                 state, next_state;
    logic [3:0]             wait_cnt;
    logic [N_IN-1:0]        pi_q;
    logic                   busy_q, done_q, fev_q;
    logic [N_IN:0]          err_q;
    logic [N_IN+HD_W-1:0]   hd_sum_q;
    logic [HD_W-1:0]        max_hd_q;
    logic [N_IN-1:0]        fep_q;
    logic [N_OUT-1:0]       diff;
    logic [HD_W-1:0]        hd;
    logic                   accept, sample, last_pat;

    assign diff     = sweep.po_exact ^ sweep.po_approx;
    assign last_pat = (pi_q == {N_IN{1'b1}});

    always_comb begin
        hd = '0;
        for (int i = 0; i < N_OUT; i++) begin
            hd = hd + HD_W'(diff[i]);
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        sample     = 1'b0;
        case (state)
            IDLE: begin
                if (sweep.start) begin
                    accept     = 1'b1;
                    next_state = (SETTLE_C != 4'd0) ? WAIT : SAMPLE;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd1) next_state = SAMPLE;
            end
            SAMPLE: begin
                sample = 1'b1;
                if (last_pat)                  next_state = DONE;
                else if (SETTLE_C != 4'd0)     next_state = WAIT;
                else                           next_state = SAMPLE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // po_* are only ever consumed in SAMPLE, the final cycle of each pattern
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            pi_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= '0;
            hd_sum_q <= '0;
            max_hd_q <= '0;
            fev_q    <= 1'b0;
            fep_q    <= '0;
        end else begin
            done_q <= sample && last_pat;
            if (accept) begin
                pi_q     <= '0;
                busy_q   <= 1'b1;
                err_q    <= '0;
                hd_sum_q <= '0;
                max_hd_q <= '0;
                fev_q    <= 1'b0;
                fep_q    <= '0;
                wait_cnt <= SETTLE_C;
            end
            if (state == WAIT) wait_cnt <= wait_cnt - 4'd1;
            if (sample) begin
                hd_sum_q <= hd_sum_q + (N_IN+HD_W)'(hd);
                if (hd != '0) begin
                    err_q <= err_q + (N_IN+1)'(1);
                    if (!fev_q) begin
                        fev_q <= 1'b1;
                        fep_q <= pi_q;
                    end
                end
                if (hd > max_hd_q) max_hd_q <= hd;
                if (last_pat) begin
                    busy_q <= 1'b0;
                end else begin
                    pi_q     <= pi_q + N_IN'(1);
                    wait_cnt <= SETTLE_C;
                end
            end
        end
    end

    assign sweep.pi            = pi_q;
    assign sweep.busy          = busy_q;
    assign sweep.done          = done_q;
    assign sweep.err_count     = err_q;
    assign sweep.hd_sum        = hd_sum_q;
    assign sweep.max_hd        = max_hd_q;
    assign sweep.first_err_vld = fev_q;
    assign sweep.first_err_pat = fep_q;
endmodule
